// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtract / less-than / equal unit, one bit per clock, LSB first.
// The borrow slice is built from counted single-bit gates whose usage is tallied in gate_counter_top.

module not_gate (
    input  logic en_i,
    input  logic a_i,
    output logic y_o,
    output logic act_o
);
    assign y_o   = ~a_i;
    assign act_o = en_i;
endmodule

module and_gate (
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic y_o,
    output logic act_o
);
    assign y_o   = a_i & b_i;
    assign act_o = en_i;
endmodule

module or_gate (
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic y_o,
    output logic act_o
);
    assign y_o   = a_i | b_i;
    assign act_o = en_i;
endmodule

module xor_gate (
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic y_o,
    output logic act_o
);
    assign y_o   = a_i ^ b_i;
    assign act_o = en_i;
endmodule

// Counts one use per gate instance each time its enable rises; cleared only by clear_i
// so that a subtractor reset does not lose the tally.
module gate_counter_top (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic [1:0]  not_act_i,
    input  logic [2:0]  and_act_i,
    input  logic [0:0]  or_act_i,
    input  logic [1:0]  xor_act_i,
    output logic [15:0] not_cnt_o,
    output logic [15:0] and_cnt_o,
    output logic [15:0] or_cnt_o,
    output logic [15:0] xor_cnt_o
);
    logic [7:0]  act, prev_q, rise;
    logic [15:0] not_cnt_q, and_cnt_q, or_cnt_q, xor_cnt_q;

    assign act  = {xor_act_i, or_act_i, and_act_i, not_act_i};
    assign rise = act & ~prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prev_q <= '0;
        else          prev_q <= act;
    end

    always_ff @(posedge clock) begin
        if (clear_i) begin
            not_cnt_q <= '0;
            and_cnt_q <= '0;
            or_cnt_q  <= '0;
            xor_cnt_q <= '0;
        end else begin
            not_cnt_q <= not_cnt_q + 16'($countones(rise[1:0]));
            and_cnt_q <= and_cnt_q + 16'($countones(rise[4:2]));
            or_cnt_q  <= or_cnt_q  + 16'($countones(rise[5:5]));
            xor_cnt_q <= xor_cnt_q + 16'($countones(rise[7:6]));
        end
    end

    assign not_cnt_o = not_cnt_q;
    assign and_cnt_o = and_cnt_q;
    assign or_cnt_o  = or_cnt_q;
    assign xor_cnt_o = xor_cnt_q;
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on start
// RUN   | one operand bit per clock through the borrow slice
// DONE  | result valid, done pulse, back to IDLE next clock
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cnt_clear_i,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic [15:0]      not_cnt_o,
    output logic [15:0]      and_cnt_o,
    output logic [15:0]      or_cnt_o,
    output logic [15:0]      xor_cnt_o
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             borrow_q, borrow_d, eq_q, eq_d;
    logic             busy_q, busy_d, done_q, done_d, bo_q, bo_d;

    logic       run_en, x, d, na, nx, gen, prop, eq_n, borrow_n;
    logic [1:0] not_act, xor_act;
    logic [2:0] and_act;
    logic [0:0] or_act;

    assign run_en = (state_q == ST_RUN);

    xor_gate u_xor_x (.en_i(run_en), .a_i(a_q[0]), .b_i(b_q[0]),   .y_o(x),        .act_o(xor_act[0]));
    xor_gate u_xor_d (.en_i(run_en), .a_i(x),      .b_i(borrow_q), .y_o(d),        .act_o(xor_act[1]));
    not_gate u_not_a (.en_i(run_en), .a_i(a_q[0]),                 .y_o(na),       .act_o(not_act[0]));
    not_gate u_not_x (.en_i(run_en), .a_i(x),                      .y_o(nx),       .act_o(not_act[1]));
    and_gate u_and_g (.en_i(run_en), .a_i(na),     .b_i(b_q[0]),   .y_o(gen),      .act_o(and_act[0]));
    and_gate u_and_p (.en_i(run_en), .a_i(nx),     .b_i(borrow_q), .y_o(prop),     .act_o(and_act[1]));
    and_gate u_and_e (.en_i(run_en), .a_i(eq_q),   .b_i(nx),       .y_o(eq_n),     .act_o(and_act[2]));
    or_gate  u_or_b  (.en_i(run_en), .a_i(gen),    .b_i(prop),     .y_o(borrow_n), .act_o(or_act[0]));

    gate_counter_top u_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (cnt_clear_i),
        .not_act_i (not_act),
        .and_act_i (and_act),
        .or_act_i  (or_act),
        .xor_act_i (xor_act),
        .not_cnt_o (not_cnt_o),
        .and_cnt_o (and_cnt_o),
        .or_cnt_o  (or_cnt_o),
        .xor_cnt_o (xor_cnt_o)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            eq_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            bo_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            eq_q     <= eq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            bo_q     <= bo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        op_d     = op_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        eq_d     = eq_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        bo_d     = bo_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    eq_d     = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                diff_d   = {d, diff_q[WIDTH-1:1]};
                borrow_d = borrow_n;
                eq_d     = eq_n;
                idx_d    = idx_q + IW'(1);
                if (idx_q == IW'(WIDTH - 1)) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = '0;
                    bo_d     = borrow_n;
                    // LT is the final borrow, EQ the final equality accumulator.
                    case (op_q)
                        2'b00:   result_d    = diff_d;
                        2'b01:   result_d[0] = borrow_n;
                        2'b10:   result_d[0] = eq_n;
                        default: bo_d        = 1'b0;
                    endcase
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign borrow_out = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table and scoreboard plus
// hand-written sequences for ignored start, mid-run reset and gate counts.
module tb_serial_subtractor;
    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cnt_clear = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done, borrow_out;
    logic [W-1:0]  result;
    logic [15:0]   not_cnt, and_cnt, or_cnt, xor_cnt;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        bo;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        bo;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    vec_t vecs[8];

    serial_subtractor #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cnt_clear_i (cnt_clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .borrow_out  (borrow_out),
        .not_cnt_o   (not_cnt),
        .and_cnt_o   (and_cnt),
        .or_cnt_o    (or_cnt),
        .xor_cnt_o   (xor_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        e.name = "rand";
        e.res  = '0;
        e.bo   = (x < y);
        case (o)
            2'b00:   e.res = x - y;
            2'b01:   e.res = {15'b0, x < y};
            2'b10:   e.res = {15'b0, x == y};
            default: e.bo = 1'b0;
        endcase
        return e;
    endfunction

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation");
            end else begin
                e_mon = sb.pop_front();
                check({e_mon.name, "_result"}, 32'(result), 32'(e_mon.res));
                check({e_mon.name, "_borrow"}, 32'(borrow_out), 32'(e_mon.bo));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) return;
            @(posedge clock);
            #1;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic start_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                            input bit push, input exp_t e);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        check({e.name, "_busy_after_start"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (done === 1'b1) return;
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, lat);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          input exp_t e);
        int lat;
        wait_idle();
        start_op(o, x, y, 1'b1, e);
        wait_done(e.name, lat);
        check({e.name, "_latency"}, 32'(lat), 32'(W));
        @(posedge clock);
        #1;
        check({e.name, "_done_width"}, 32'(done), 32'd0);
        check({e.name, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   lat;
        int   done_before;
        logic [1:0]  ro;
        logic [15:0] ra, rb;

        vecs[0] = '{2'b00, 16'h0005, 16'h0003, 16'h0002, 1'b0, "sub_5_3"};
        vecs[1] = '{2'b00, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, "sub_3_5"};
        vecs[2] = '{2'b01, 16'h1234, 16'h1235, 16'h0001, 1'b1, "lt_true"};
        vecs[3] = '{2'b01, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, "lt_max_zero"};
        vecs[4] = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 1'b0, "lt_equal"};
        vecs[5] = '{2'b10, 16'hA5A5, 16'hA5A5, 16'h0001, 1'b0, "eq_true"};
        vecs[6] = '{2'b10, 16'hA5A5, 16'hA5A4, 16'h0000, 1'b0, "eq_false"};
        vecs[7] = '{2'b11, 16'h0003, 16'h0005, 16'h0000, 1'b0, "reserved"};

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("cnt_cleared_not", 32'(not_cnt), 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        cnt_clear = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e.res  = vecs[i].res;
            e.bo   = vecs[i].bo;
            e.name = vecs[i].name;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, e);
            if (i == 1) begin
                check("cnt_not", 32'(not_cnt), 32'd4);
                check("cnt_and", 32'(and_cnt), 32'd6);
                check("cnt_or",  32'(or_cnt),  32'd2);
                check("cnt_xor", 32'(xor_cnt), 32'd4);
            end
        end

        for (int i = 0; i < 4; i++) begin
            ro = 2'($urandom_range(0, 2));
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ro, ra, rb, model(ro, ra, rb));
        end

        // Second request arrives while bit 5 is being processed and must be dropped.
        done_before = done_seen;
        e.res  = 16'h000F;
        e.bo   = 1'b0;
        e.name = "sub_ignore";
        wait_idle();
        start_op(2'b00, 16'h0010, 16'h0001, 1'b1, e);
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1;
        op    = 2'b00;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        wait_done("sub_ignore", lat);
        check("sub_ignore_latency", 32'(lat + 6), 32'(W));
        repeat (5) @(posedge clock);
        #1;
        check("ignore_no_second_busy", 32'(busy), 32'd0);
        check("ignore_single_done", 32'(done_seen - done_before), 32'd1);

        // Asynchronous reset in the middle of a run.
        e.name = "aborted";
        start_op(2'b00, 16'h1234, 16'h0001, 1'b0, e);
        repeat (4) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_borrow", 32'(borrow_out), 32'd0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("aborted_no_busy", 32'(busy), 32'd0);

        e.res  = 16'h0000;
        e.bo   = 1'b0;
        e.name = "sub_1_1";
        run_op(2'b00, 16'h0001, 16'h0001, e);

        repeat (3) @(posedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Multi-cycle, bit-serial unsigned subtract/compare unit: the borrow-chain counterpart of the ripple-carry adder.
- Implements SUB, LT and EQ/COMP for the processor's ALU.
- Processes one bit per clock, LSB first, through a one-bit slice built from the counted single-bit gate modules (`not_gate`, `and_gate`, `or_gate`, `xor_gate`), so per-operation gate usage is reflected in `gate_counter_top`.
- The ALU issues operands with a start pulse and captures the result on `done`.

## Interface
- `WIDTH`, 16: operand and result width in bits.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  2: operation select.
  - 2'b00: SUB.
  - 2'b01: LT, unsigned.
  - 2'b10: EQ.
  - 2'b11: reserved.
- `a`  in  WIDTH: minuend / left operand; captured with `start`.
- `b`  in  WIDTH: subtrahend / right operand; captured with `start`.
- `busy`  out  1: high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1: one-cycle pulse; `result` and `borrow_out` are valid from this cycle on.
- `result`  out  WIDTH: result of the operation; held until the next `done`.
  - SUB: `a - b` modulo 2^WIDTH.
  - LT: zero-extended 1 if `a < b`.
  - EQ: zero-extended 1 if `a == b`.
  - Reserved op: 0.
- `borrow_out`  out  1: final borrow out of the MSB for every op except reserved, where it is 0; held until the next `done`.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE to RUN: `start` = 1.
  - Latch `a`, `b`, `op` into shift registers.
  - Clear the bit index.
  - Set borrow = 0 and eq_acc = 1.
- RUN, each cycle on bit i (i = 0..WIDTH-1):
  - x = a_i ^ b_i.
  - d_i = x ^ borrow.
  - borrow' = (~a_i & b_i) | (~x & borrow).
  - eq_acc' = eq_acc & ~x.
  - d_i shifts into the difference register at the MSB end; the operand registers shift right.
- RUN to DONE: after bit WIDTH-1 is processed (index counter at WIDTH-1). On that edge `result` and `borrow_out` are loaded per `op` and `done` is set.
- DONE to IDLE: unconditional, one cycle later. `done` clears; `busy` clears.
- `start` is ignored in RUN and DONE: no queuing, and latched operands are unaffected.
- Arithmetic is unsigned. LT is defined as the final borrow; EQ as the final eq_acc. Both are computed for every op; `op` only selects the result.
- Gate slice per bit:
  - XOR: 2 instances (x, d).
  - NOT: 2 instances (~a_i, ~x).
  - AND: 3 instances (~a_i & b_i, ~x & borrow, eq_acc & ~x).
  - OR: 1 instance.
- Gate enables are driven by (state == RUN). The enable rises exactly once per operation, so each accepted operation adds NOT+2, AND+3, OR+1, XOR+2 to the counters.
- Reset (`reset_n` low, any state, including mid-RUN):
  - Immediately: state IDLE, `busy` = 0, `done` = 0, `result` = 0, `borrow_out` = 0.
  - Internal registers cleared.
  - The partial operation is discarded; gate counters are not reset.

## Timing
- Edge 0 samples `start` in IDLE; `busy` = 1 after edge 0.
- Edges 1..WIDTH process bits 0..WIDTH-1.
- After edge WIDTH: `done` = 1 and result valid, a latency of WIDTH clocks (16 by default).
- After edge WIDTH+1: `done` = 0, `busy` = 0, IDLE.
- Minimum issue interval is WIDTH+2 clocks: `start` may be reasserted in the cycle after `done` falls.
- `start` held high continuously starts a new operation each time IDLE is entered.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `busy` 0, `done` 0, `result` 0, `borrow_out` 0.

## Test plan
- SUB, a=0x0005, b=0x0003 -> `result` 0x0002, `borrow_out` 0, `done` exactly 16 edges after start, one cycle wide.
- SUB, a=0x0003, b=0x0005 -> `result` 0xFFFE, `borrow_out` 1.
- LT:
  - 0x1234 vs 0x1235 -> 0x0001.
  - 0xFFFF vs 0x0000 -> 0x0000.
  - 0x8000 vs 0x8000 -> 0x0000.
- EQ:
  - 0xA5A5 vs 0xA5A5 -> 0x0001.
  - 0xA5A5 vs 0xA5A4 -> 0x0000.
  - op=2'b11 -> `result` 0x0000, `borrow_out` 0.
- SUB 0x0010 - 0x0001 started, then `start` with 0xFFFF/0xFFFF pulsed at bit 5 -> `result` 0x000F, second request not executed.
  - Then `reset_n` low mid-RUN of a new op -> all outputs 0 asynchronously, no `done`.
  - After reset release, SUB 0x0001 - 0x0001 -> 0x0000.
- Two back-to-back ops from zeroed `gate_counter_top` -> counts NOT=4, AND=6, OR=2, XOR=4.
